// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
//   - Output mux select codes that choose the bit driven onto the serial line.
//   - FSM state encoding.
// Configuration macro: UART_TX_STOP2_EN adds a second stop-bit state (ST_STOP2).
package uart_tx_pkg;

  // Output bit mux select codes
  localparam logic [1:0] SEL_START  = 2'b00;  // line driven low (start bit)
  localparam logic [1:0] SEL_IDLE   = 2'b01;  // line driven high (idle / stop)
  localparam logic [1:0] SEL_DATA   = 2'b10;  // serializer output
  localparam logic [1:0] SEL_PARITY = 2'b11;  // parity_calc output

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
    ST_STOP2  = 3'd5,
`endif
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start -> data -> [parity] -> stop [-> stop2],
// one bit per clk. Holds no payload; drives the serializer, parity capture and
// output mux.
//
// Ports:
//   clk        in   bit clock, one UART bit period per cycle
//   reset      in   synchronous active-low reset
//   Data_Valid in   frame request, sampled only in IDLE
//   PAR_EN     in   parity enable, captured with an accepted Data_Valid
//   data_load  out  combinational load strobe (IDLE & Data_Valid)
//   ser_en     out  registered serializer shift enable (high in DATA)
//   mux_sel    out  registered output mux select
//   busy       out  registered frame-in-progress flag
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: Data_Valid is a request with an implicit ready of (state==IDLE);
// a request is taken on the clk edge where both hold, and data_load marks that
// cycle. Requests seen while busy are dropped, not queued.
//
// Configuration: define UART_TX_STOP2_EN for two stop bits.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int FRAME_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       data_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic [1:0]       mux_sel_q, mux_sel_d;

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Data_Valid) begin
          par_en_d  = PAR_EN;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        // Counter saturates on the last data bit so it never wraps.
        if (bit_cnt_q == CNT_LAST) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_PARITY: state_d = ST_STOP;
`ifdef UART_TX_STOP2_EN
      ST_STOP:  state_d = ST_STOP2;
      ST_STOP2: state_d = ST_IDLE;
`else
      ST_STOP:  state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state and registered, so they line up
  // with the state register with no decode glitches on the pins.
  always_comb begin
    ser_en_d  = (state_d == ST_DATA);
    busy_d    = (state_d != ST_IDLE);
    mux_sel_d = SEL_IDLE;
    unique case (state_d)
      ST_START:  mux_sel_d = SEL_START;
      ST_DATA:   mux_sel_d = SEL_DATA;
      ST_PARITY: mux_sel_d = SEL_PARITY;
      default:   mux_sel_d = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      mux_sel_q <= SEL_IDLE;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  assign data_load = (state_q == ST_IDLE) & Data_Valid;
  assign ser_en    = ser_en_q;
  assign busy      = busy_q;
  assign mux_sel   = mux_sel_q;
  assign dbg_state = state_q;

endmodule
